// File: rtl/rst_btn_ctrl.sv
// rst_btn_ctrl: board-pin front end for the core.
//   - SYNC_STAGES-deep synchronizers on the slide switches and push-buttons
//   - per-button debouncer (only when RST_BTN_DEBOUNCE_EN is defined; otherwise
//     Button is the synchronized level registered once more)
//   - one-cycle press pulses, masked while the core is held in reset or a reset
//     request is active
//   - core reset sequencer: CoreRst is held for RST_HOLD_CYCLES edges after
//     power-up and after a Button[0] + Switch[9] reset request is released
// Optional feature macro: RST_BTN_DEBOUNCE_EN
module rst_btn_ctrl #(
   parameter int DEB_CYCLES      = 1_000_000,
   parameter int RST_HOLD_CYCLES = 16,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       Clock,
   input  logic       Rst_N,
   input  logic [1:0] Button_N,
   input  logic [9:0] Switch,
   output logic       CoreRst,
   output logic [1:0] Button,
   output logic [1:0] Button_Pulse,
   output logic [9:0] Switch_Sync
);

   localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } rst_state_t;

   // Elaboration-time guard on parameter ranges
   if ((DEB_CYCLES < 1) || (RST_HOLD_CYCLES < 1) || (SYNC_STAGES < 2)) begin : g_param_chk
      $error("rst_btn_ctrl: parameter out of range");
   end

   // synchronizer chains, stage 0 samples the pin, stage SYNC_STAGES-1 is the output
   logic [SYNC_STAGES-1:0][9:0] sw_sync_r;
   logic [SYNC_STAGES-1:0][1:0] btn_sync_r;

   logic [1:0]        btn_s;           // synchronized, active-high button level
   logic [1:0]        button_r;
   logic [1:0]        button_next_s;
   logic [1:0]        button_prev_r;
   logic [1:0]        rise_s;
   logic [1:0]        pulse_r;
   logic              rst_req_s;
   logic              rst_req_next_s;
   rst_state_t        state_r;
   rst_state_t        state_next_s;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [HOLD_W-1:0] hold_cnt_next_s;
   logic              core_rst_r;
   logic              core_rst_next_s;

   // Synchronizer shift chains; button chains preset to "released" (high)
   always_ff @(posedge Clock or negedge Rst_N) begin
      if (!Rst_N) begin
         sw_sync_r  <= '0;
         btn_sync_r <= '1;
      end else begin
         sw_sync_r  <= {sw_sync_r[SYNC_STAGES-2:0], Switch};
         btn_sync_r <= {btn_sync_r[SYNC_STAGES-2:0], Button_N};
      end
   end

   assign btn_s = ~btn_sync_r[SYNC_STAGES-1];

`ifdef RST_BTN_DEBOUNCE_EN
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [1:0][DEB_W-1:0] deb_cnt_r;
   logic [1:0][DEB_W-1:0] deb_cnt_next_s;

   // Debounce decision: the counter measures how long btn_s has disagreed with Button
   always_comb begin
      deb_cnt_next_s = '0;
      button_next_s  = button_r;
      for (int i = 0; i < 2; i++) begin
         if (btn_s[i] == button_r[i]) begin
            deb_cnt_next_s[i] = '0;
         end else if (deb_cnt_r[i] == DEB_LAST) begin
            button_next_s[i]  = btn_s[i];
            deb_cnt_next_s[i] = '0;
         end else begin
            deb_cnt_next_s[i] = deb_cnt_r[i] + DEB_W'(1);
         end
      end
   end

   // Debounce counter registers
   always_ff @(posedge Clock or negedge Rst_N) begin
      if (!Rst_N) begin
         deb_cnt_r <= '0;
      end else begin
         deb_cnt_r <= deb_cnt_next_s;
      end
   end
`else
   // Without debouncing the button level simply follows the synchronizer
   assign button_next_s = btn_s;
`endif

   // Debounced button level and its one-cycle-delayed copy for edge detection
   always_ff @(posedge Clock or negedge Rst_N) begin
      if (!Rst_N) begin
         button_r      <= 2'b00;
         button_prev_r <= 2'b00;
      end else begin
         button_r      <= button_next_s;
         button_prev_r <= button_r;
      end
   end

   // reset request now, and as it will read after the coming edge
   assign rst_req_s      = button_r[0] & sw_sync_r[SYNC_STAGES-1][9];
   assign rst_req_next_s = button_next_s[0] & sw_sync_r[SYNC_STAGES-2][9];

   // Reset sequencer next-state and hold counter
   always_comb begin
      state_next_s    = state_r;
      hold_cnt_next_s = hold_cnt_r;
      case (state_r)
         ST_INIT: begin
            if (hold_cnt_r == HOLD_LAST) begin
               hold_cnt_next_s = '0;
               if (rst_req_s) begin
                  state_next_s = ST_HOLD;
               end else begin
                  state_next_s = ST_RUN;
               end
            end else begin
               hold_cnt_next_s = hold_cnt_r + HOLD_W'(1);
            end
         end
         ST_RUN: begin
            hold_cnt_next_s = '0;
            if (rst_req_s) begin
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_HOLD: begin
            hold_cnt_next_s = '0;
            if (rst_req_s) begin
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_INIT;
            end
         end
         default: begin
            hold_cnt_next_s = '0;
            state_next_s    = ST_INIT;
         end
      endcase
   end

   assign core_rst_next_s = (state_next_s != ST_RUN);

   // Reset sequencer state, counter and the registered core reset
   always_ff @(posedge Clock or negedge Rst_N) begin
      if (!Rst_N) begin
         state_r    <= ST_INIT;
         hold_cnt_r <= '0;
         core_rst_r <= 1'b1;
      end else begin
         state_r    <= state_next_s;
         hold_cnt_r <= hold_cnt_next_s;
         core_rst_r <= core_rst_next_s;
      end
   end

   // A press pulse is suppressed in any cycle where the core is in reset or a
   // reset request is active, so the gate uses the values valid in the pulse cycle
   assign rise_s = button_r & ~button_prev_r;

   // Press pulse register
   always_ff @(posedge Clock or negedge Rst_N) begin
      if (!Rst_N) begin
         pulse_r <= 2'b00;
      end else begin
         pulse_r <= rise_s & ~{2{core_rst_next_s | rst_req_next_s}};
      end
   end

   assign CoreRst      = core_rst_r;
   assign Button       = button_r;
   assign Button_Pulse = pulse_r;
   assign Switch_Sync  = sw_sync_r[SYNC_STAGES-1];

endmodule
